// File: rtl/ram_port_arbiter_if.sv
// Purpose: one requester's access channel plus its read-response channel.
// Latency: none, plain wires between requester and arbiter.
// Backpressure: valid/ready on both the request and the response channels.
interface ram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_data;

   // Requester side: drives the access and consumes the response.
   modport master (
      output valid, we, addr, wdata, resp_ready,
      input  ready, resp_valid, resp_data
   );

   // Arbiter side: grants the access and produces the response.
   modport slave (
      input  valid, we, addr, wdata, resp_ready,
      output ready, resp_valid, resp_data
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one block-RAM port between two requesters, round-robin (fixed priority with RAM_ARB_FIXED_PRIO_EN).
// Latency: grant is combinational; read data appears in the response register 2 cycles after the grant edge.
// Backpressure: a requester is not granted while its read is in flight or its response is held unconsumed.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   ram_port_arbiter_if.slave     req0,
   ram_port_arbiter_if.slave     req1,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   logic [1:0]                 req_valid;
   logic [1:0]                 req_we;
   logic [1:0]                 resp_ready;
   logic [1:0]                 elig;
   logic [1:0]                 grant;
   logic [1:0]                 inflight;
   logic [1:0]                 resp_valid;
   logic [1:0][DATA_WIDTH-1:0] resp_data;

   assign req_valid  = {req1.valid, req0.valid};
   assign req_we     = {req1.we, req0.we};
   assign resp_ready = {req1.resp_ready, req0.resp_ready};

   // A requester may issue only once its previous read has landed and its
   // response slot is free (or being freed on this edge). Writes follow the
   // same rule so a write can never overtake an outstanding read.
   assign elig = req_valid & ~inflight & (~resp_valid | resp_ready);

`ifdef RAM_ARB_FIXED_PRIO_EN
   // Fixed priority: requester 0 wins every tie, requester 1 may starve.
   always_comb begin
      grant = 2'b00;
      if (elig[0]) begin
         grant[0] = 1'b1;
      end else if (elig[1]) begin
         grant[1] = 1'b1;
      end
   end
`else
   // Index of the most recently granted requester; reset to 1 so requester 0
   // wins the first tie.
   logic last_grant;

   // Round-robin: on a tie, grant whoever was not granted last.
   always_comb begin
      grant = elig;
      if (elig[0] && elig[1]) begin
         grant[0] = last_grant;
         grant[1] = ~last_grant;
      end
   end

   // Remember the winner of every grant for the next tie-break.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end
`endif

   assign req0.ready = grant[0];
   assign req1.ready = grant[1];

   // Steer the granted requester onto the RAM port; idle port drives zeros.
   always_comb begin
      ram_en    = |grant;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (grant[0]) begin
         ram_we    = req0.we;
         ram_addr  = req0.addr;
         ram_wdata = req0.wdata;
      end else if (grant[1]) begin
         ram_we    = req1.we;
         ram_addr  = req1.addr;
         ram_wdata = req1.wdata;
      end
   end

   // Per-requester read tracking: a granted read is in flight for exactly one
   // cycle, then the RAM's registered output is captured into that
   // requester's own response register. ram_rdata is never passed through
   // directly because the RAM register also changes on later accesses.
   // inflight implies resp_valid is already clear, so capture and accept
   // never collide.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight   <= 2'b00;
         resp_valid <= 2'b00;
         resp_data  <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (inflight[n]) begin
               resp_data[n]  <= ram_rdata;
               resp_valid[n] <= 1'b1;
               inflight[n]   <= 1'b0;
            end else begin
               if (resp_valid[n] && resp_ready[n]) begin
                  resp_valid[n] <= 1'b0;
               end
               if (grant[n] && !req_we[n]) begin
                  inflight[n] <= 1'b1;
               end
            end
         end
      end
   end

   assign req0.resp_valid = resp_valid[0];
   assign req0.resp_data  = resp_data[0];
   assign req1.resp_valid = resp_valid[1];
   assign req1.resp_data  = resp_data[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: self-checking bench for ram_port_arbiter with a behavioural RAM and a cycle model plus read scoreboard.
// Latency: model predicts grants each cycle and read data 2 cycles after grant.
// Backpressure: response-ready is held low in one phase and randomised in another.
module tb_ram_port_arbiter;
   localparam int AW = 15;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
   ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req0      (r0_if),
      .req1      (r1_if),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Initial RAM contents: a hash of the address, with the known word at 0x10.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 15'h0010) return 32'hDEADBEEF;
      return ({17'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Behavioural RAM: registered read (old data on a write cycle).
   logic [DW-1:0] ram_mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
         if (ram_we) ram_mem[ram_addr] = ram_wdata;
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state.
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic          m_last;
   logic [1:0]    m_inf;
   logic [1:0]    m_rv;
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Cycle model: predict grants and RAM drive, check responses against the
   // scoreboard, then advance the model to the next active edge.
   always @(negedge clk) begin : mon
      logic e0, e1, g0, g1;
      if (!rstn) begin
         m_last = 1'b1;
         m_inf  = 2'b00;
         m_rv   = 2'b00;
         q0.delete();
         q1.delete();
         chk("rst_rv0", r0_if.resp_valid, 0);
         chk("rst_rv1", r1_if.resp_valid, 0);
      end else begin
         e0 = r0_if.valid & ~m_inf[0] & (~m_rv[0] | r0_if.resp_ready);
         e1 = r1_if.valid & ~m_inf[1] & (~m_rv[1] | r1_if.resp_ready);
`ifdef RAM_ARB_FIXED_PRIO_EN
         g0 = e0;
         g1 = e1 & ~e0;
`else
         if (e0 && e1) begin
            g0 = m_last;
            g1 = ~m_last;
         end else begin
            g0 = e0;
            g1 = e1;
         end
`endif
         chk("m_rdy0", r0_if.ready, g0);
         chk("m_rdy1", r1_if.ready, g1);
         chk("m_en", ram_en, g0 | g1);
         if (g0) begin
            chk("m_we0", ram_we, r0_if.we);
            chk("m_addr0", ram_addr, r0_if.addr);
            if (r0_if.we) chk("m_wd0", ram_wdata, r0_if.wdata);
         end
         if (g1) begin
            chk("m_we1", ram_we, r1_if.we);
            chk("m_addr1", ram_addr, r1_if.addr);
            if (r1_if.we) chk("m_wd1", ram_wdata, r1_if.wdata);
         end
         chk("m_rv0", r0_if.resp_valid, m_rv[0]);
         chk("m_rv1", r1_if.resp_valid, m_rv[1]);
         if (m_rv[0]) begin
            if (q0.size() == 0) chk("sb0_size", q0.size(), 1);
            else                chk("sb0_data", r0_if.resp_data, q0[0]);
         end
         if (m_rv[1]) begin
            if (q1.size() == 0) chk("sb1_size", q1.size(), 1);
            else                chk("sb1_data", r1_if.resp_data, q1[0]);
         end
         // advance to the next edge
         if (m_inf[0]) begin
            m_rv[0] = 1'b1; m_inf[0] = 1'b0;
         end else if (m_rv[0] && r0_if.resp_ready) begin
            m_rv[0] = 1'b0;
            if (q0.size() > 0) void'(q0.pop_front());
         end
         if (m_inf[1]) begin
            m_rv[1] = 1'b1; m_inf[1] = 1'b0;
         end else if (m_rv[1] && r1_if.resp_ready) begin
            m_rv[1] = 1'b0;
            if (q1.size() > 0) void'(q1.pop_front());
         end
         if (g0) begin
            if (r0_if.we) ref_mem[r0_if.addr] = r0_if.wdata;
            else begin m_inf[0] = 1'b1; q0.push_back(ref_rd(r0_if.addr)); end
         end
         if (g1) begin
            if (r1_if.we) ref_mem[r1_if.addr] = r1_if.wdata;
            else begin m_inf[1] = 1'b1; q1.push_back(ref_rd(r1_if.addr)); end
         end
         if (g0 | g1) m_last = g1;
      end
   end

   task automatic drv0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      r0_if.valid = v; r0_if.we = we; r0_if.addr = a; r0_if.wdata = d;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      r1_if.valid = v; r1_if.we = we; r1_if.addr = a; r1_if.wdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drv0(1'b0, 1'b0, '0, '0);
      drv1(1'b0, 1'b0, '0, '0);
      repeat (n) step();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   initial begin : stim
      int cnt0, cnt1, k;
      rstn = 1'b0;
      drv0(1'b0, 1'b0, '0, '0);
      drv1(1'b0, 1'b0, '0, '0);
      r0_if.resp_ready = 1'b1;
      r1_if.resp_ready = 1'b1;
      repeat (2) step();
      @(negedge clk);
      chk("rst_rd0", r0_if.resp_data, 0);
      chk("rst_rd1", r1_if.resp_data, 0);
      chk("rst_en", ram_en, 0);
      step();
      rstn = 1'b1;

      // T1: single read of 0x10
      drv0(1'b1, 1'b0, 15'h0010, '0);
      @(negedge clk); chk("t1_rdy0_c0", r0_if.ready, 1);
      step(); drv0(1'b0, 1'b0, '0, '0);
      @(negedge clk); chk("t1_rv0_c1", r0_if.resp_valid, 0);
      @(negedge clk); chk("t1_rv0_c2", r0_if.resp_valid, 1);
      chk("t1_rd0", r0_if.resp_data, 32'hDEADBEEF);
      step();

      // T2: both read every cycle, grants alternate
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 20; i++) begin
         drv0(1'b1, 1'b0, AW'(i), '0);
         drv1(1'b1, 1'b0, AW'(100 + i), '0);
         @(negedge clk);
         chk("t2_one_grant", r0_if.ready ^ r1_if.ready, 1);
         cnt0 += int'(r0_if.ready);
         cnt1 += int'(r1_if.ready);
         step();
      end
      chk("t2_cnt0", cnt0, 10);
      chk("t2_cnt1", cnt1, 10);
      idle(4);

      // T3: response 1 backpressured, req0 keeps going
      r1_if.resp_ready = 1'b0;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 12; i++) begin
         drv0(1'b1, 1'b0, AW'(200 + i), '0);
         drv1(1'b1, 1'b0, 15'h0005, '0);
         @(negedge clk);
         cnt0 += int'(r0_if.ready);
         cnt1 += int'(r1_if.ready);
         step();
      end
      chk("t3_cnt1", cnt1, 1);
      chk("t3_cnt0_ge5", (cnt0 >= 5) ? 1 : 0, 1);
      chk("t3_rv1_held", r1_if.resp_valid, 1);
      chk("t3_rd1", r1_if.resp_data, init_val(15'h0005));
      r1_if.resp_ready = 1'b1;
      idle(4);

      // T4: write at T, read same address at T+1
      drv0(1'b1, 1'b1, 15'h0020, 32'h12345678);
      @(negedge clk); chk("t4_wr_rdy0", r0_if.ready, 1);
      step();
      drv0(1'b0, 1'b0, '0, '0);
      drv1(1'b1, 1'b0, 15'h0020, '0);
      @(negedge clk); chk("t4_rd_rdy1", r1_if.ready, 1);
      step();
      drv1(1'b0, 1'b0, '0, '0);
      k = 0;
      @(negedge clk);
      while (!r1_if.resp_valid && k < 8) begin @(negedge clk); k++; end
      chk("t4_rv1", r1_if.resp_valid, 1);
      chk("t4_rd1", r1_if.resp_data, 32'h12345678);
      idle(3);

      // T5: reset between accept and capture
      drv0(1'b1, 1'b0, 15'h0010, '0);
      @(negedge clk); chk("t5_rdy0", r0_if.ready, 1);
      step();
      drv0(1'b0, 1'b0, '0, '0);
      rstn = 1'b0;
      repeat (2) step();
      rstn = 1'b1;
      @(negedge clk); chk("t5_rv0_after", r0_if.resp_valid, 0);
      step();
      drv0(1'b1, 1'b0, 15'h0030, '0);
      drv1(1'b1, 1'b0, 15'h0031, '0);
      @(negedge clk);
      chk("t5_first_rdy0", r0_if.ready, 1);
      chk("t5_first_rdy1", r1_if.ready, 0);
      step();
      idle(4);

      // T6: req0 writes every cycle while req1 reads
      cnt1 = 0;
      for (int i = 0; i < 16; i++) begin
         drv0(1'b1, 1'b1, AW'(300 + i), $urandom);
         drv1(1'b1, 1'b0, AW'(300 + i), '0);
         @(negedge clk);
         cnt1 += int'(r1_if.ready);
         step();
      end
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("t6_cnt1", cnt1, 0);
`else
      chk("t6_cnt1", cnt1, 8);
`endif
      idle(4);

      // T7: random traffic over a small address window
      for (int i = 0; i < 300; i++) begin
         drv0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         drv1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
         r0_if.resp_ready = 1'($urandom_range(0, 1));
         r1_if.resp_ready = 1'($urandom_range(0, 1));
         step();
      end
      r0_if.resp_ready = 1'b1;
      r1_if.resp_ready = 1'b1;
      idle(5);
      @(negedge clk);
      chk("end_q0_empty", q0.size(), 0);
      chk("end_q1_empty", q1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
